program_load_ingest: RTL and testbench
======================================

Name: program_load_ingest

Overview:
Sits inside Briey_Wrap, directly downstream of the program-loader AW/W channels. Accepts 64-byte program-load beats (address + 512-bit data + 64-bit strobe) while program_load_en is high. Serialises each beat into 32-bit word writes on the core's on-chip RAM write port, honouring byte strobes. Provides busy/error status to the wrapper's reset sequencing.

Parameters:
DATA_WIDTH, 512, load beat width in bits; must be a multiple of WORD_WIDTH.
WORD_WIDTH, 32, RAM write-port width in bits.
ADDR_WIDTH, 15, byte address width of the program-load AW channel.

Ports:
axi4_mm_clk  in  1  clock
axi4_mm_rst_n  in  1  asynchronous active-low reset
program_load_en  in  1  load window; low aborts and blocks acceptance
program_load_aw_valid  in  1  address valid
program_load_aw_ready  out  1  address ready
program_load_aw_payload_addr  in  ADDR_WIDTH  beat byte address
program_load_w_valid  in  1  data valid
program_load_w_ready  out  1  data ready
program_load_w_payload_data  in  DATA_WIDTH  beat data, byte 0 in bits [7:0]
program_load_w_payload_strb  in  DATA_WIDTH/8  byte strobes
ram_we  out  1  word write strobe
ram_ready  in  1  RAM accepts write this cycle
ram_addr  out  ADDR_WIDTH-2  word address
ram_wdata  out  WORD_WIDTH  word data
ram_wmask  out  WORD_WIDTH/8  byte mask
load_busy  out  1  beat in flight
load_err  out  1  sticky misaligned-address flag
load_beats  out  16  count of beats fully written
load_checksum  out  32  see Optional Feature

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0; state IDLE; index 0; counters 0.
- States: IDLE, SPLIT.
- IDLE: aw_ready = en & w_valid; w_ready = en & aw_valid. AW and W are always accepted together in the same cycle; a lone valid on either channel waits. Ready may depend on valid; valid never depends on ready.
- On acceptance:
  - Latch data, strb, and addr aligned down to 64 B.
  - If addr[5:0] != 0, set load_err (sticky until reset).
  - Go to SPLIT with index = 0; load_busy = 1.
- SPLIT: word i uses data[32i+31:32i], mask strb[4i+3:4i], ram_addr = base_word + i.
  - Mask != 0: ram_we = 1; hold all ram_* outputs stable until ram_ready; advance on ram_we & ram_ready.
  - Mask == 0: word is skipped in the same cycle, with no ram_we and no wait.
  - After the last word (i = DATA_WIDTH/WORD_WIDTH − 1) advances, increment load_beats (saturating at 0xFFFF) and return to IDLE.
- Latency: acceptance at cycle N gives the first ram_we at N+1. A fully-strobed beat with ram_ready tied high takes 16 cycles, and the next beat is accepted at N+17. aw_ready and w_ready are low throughout SPLIT.
- Address wrap: ram_addr computed modulo 2^(ADDR_WIDTH−2); no error.
- program_load_en low in SPLIT: abort next edge. ram_we drops, go to IDLE, discard the remaining words, load_beats not incremented, load_err and load_beats retained.
- en low in IDLE: both readies 0.
- An all-zero-strobe beat returns to IDLE after 16 cycles with no writes and increments load_beats.

Optional Feature:
- Macro PROGRAM_LOAD_CHECKSUM_EN.
- Defined: load_checksum accumulates a 32-bit wrapping sum of (ram_wdata & byte-expanded ram_wmask) on every ram_we & ram_ready. It clears on reset only.
- Undefined: load_checksum tied to 0 and no accumulator logic is built.

Test Plan:
- Basic beat: addr 0x0040, data word i = i, strb all 1s, ram_ready = 1 -> ram_addr 0x10..0x1F with wdata 0..15, wmask 0xF; load_beats = 1; busy low at cycle 17.
- Channel skew: aw_valid 3 cycles before w_valid -> both readies rise in the same cycle as w_valid; exactly one beat accepted.
- Sparse strobe: strb = 0x0000_0000_0000_00F0 -> single write ram_addr base+1 with wmask 0xF; beat completes in 16 cycles.
- Backpressure: ram_ready low for 5 cycles at word 3 -> ram_addr, ram_wdata and ram_wmask held constant; word 4 not issued early.
- Abort and misalign: program_load_en dropped at word 7 -> no further ram_we, load_beats unchanged. Then a beat at addr 0x0044 -> load_err = 1, writes start at word address 0x10.
- Checksum (macro on): two beats of all 0x01010101 words -> load_checksum = 0x20202020.

Source files
------------

// File: rtl/program_load_ingest.sv
// program_load_ingest: splits 512-bit program-load beats into byte-masked 32-bit RAM writes (define PROGRAM_LOAD_CHECKSUM_EN for load_checksum)
module program_load_ingest #(
    parameter int DATA_WIDTH = 512,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    axi4_mm_clk,
    input  logic                    axi4_mm_rst_n,
    input  logic                    program_load_en,
    input  logic                    program_load_aw_valid,
    output logic                    program_load_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   program_load_aw_payload_addr,
    input  logic                    program_load_w_valid,
    output logic                    program_load_w_ready,
    input  logic [DATA_WIDTH-1:0]   program_load_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0] program_load_w_payload_strb,
    output logic                    ram_we,
    input  logic                    ram_ready,
    output logic [ADDR_WIDTH-3:0]   ram_addr,
    output logic [WORD_WIDTH-1:0]   ram_wdata,
    output logic [WORD_WIDTH/8-1:0] ram_wmask,
    output logic                    load_busy,
    output logic                    load_err,
    output logic [15:0]             load_beats,
    output logic [31:0]             load_checksum
);
    localparam int NW  = DATA_WIDTH / WORD_WIDTH;
    localparam int IW  = $clog2(NW);
    localparam int WB  = WORD_WIDTH / 8;
    localparam int OFF = $clog2(DATA_WIDTH / 8);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [ADDR_WIDTH-OFF-1:0] base_q, base_d;
    logic                    err_q, err_d;
    logic [15:0]             beats_q, beats_d;

    // Handshake, word selection and the IDLE/SPLIT walk; the word address is the beat base with the word index appended, so it wraps naturally
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        base_d  = base_q;
        err_d   = err_q;
        beats_d = beats_q;
        program_load_aw_ready = (state_q == IDLE) && program_load_en && program_load_w_valid;
        program_load_w_ready  = (state_q == IDLE) && program_load_en && program_load_aw_valid;
        ram_addr  = {base_q, idx_q};
        ram_wdata = data_q[idx_q*WORD_WIDTH +: WORD_WIDTH];
        ram_wmask = strb_q[idx_q*WB +: WB];
        ram_we    = (state_q == SPLIT) && program_load_en && (ram_wmask != '0);
        if (program_load_aw_ready && program_load_aw_valid) begin
            state_d = SPLIT;
            idx_d   = '0;
            data_d  = program_load_w_payload_data;
            strb_d  = program_load_w_payload_strb;
            base_d  = program_load_aw_payload_addr[ADDR_WIDTH-1:OFF];
            err_d   = err_q || (program_load_aw_payload_addr[OFF-1:0] != '0);
        end else if (state_q == SPLIT) begin
            if (!program_load_en) begin
                state_d = IDLE;
            end else if (!ram_we || ram_ready) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NW - 1)) begin
                    state_d = IDLE;
                    beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
                end
            end
        end
    end

    // Beat capture, walk position and status registers
    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            base_q  <= base_d;
            err_q   <= err_d;
            beats_q <= beats_d;
        end
    end

    assign load_busy  = (state_q == SPLIT);
    assign load_err   = err_q;
    assign load_beats = beats_q;

`ifdef PROGRAM_LOAD_CHECKSUM_EN
    logic [31:0]           chk_q, chk_d;
    logic [WORD_WIDTH-1:0] mask_bits;

    // Add each written word, with unstrobed bytes zeroed, into a wrapping sum
    always_comb begin
        mask_bits = '0;
        for (int b = 0; b < WB; b++) mask_bits[b*8 +: 8] = {8{ram_wmask[b]}};
        chk_d = (ram_we && ram_ready) ? chk_q + 32'(ram_wdata & mask_bits) : chk_q;
    end

    // Checksum register, cleared only by reset
    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
        if (!axi4_mm_rst_n) chk_q <= '0;
        else chk_q <= chk_d;
    end

    assign load_checksum = chk_q;
`else
    assign load_checksum = '0;
`endif
endmodule

// File: tb/tb_program_load_ingest.sv
// tb_program_load_ingest: directed self-checking bench for program_load_ingest
module tb_program_load_ingest;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, awv, awr, wv, wr;
    logic [14:0]  addr;
    logic [511:0] wdat;
    logic [63:0]  strb;
    logic         ram_we, ram_ready;
    logic [12:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic [3:0]   ram_wmask;
    logic         busy, err;
    logic [15:0]  beats;
    logic [31:0]  csum;

    int cmp = 0;
    int bad = 0;

    logic [12:0] wa [$];
    logic [31:0] wd [$];
    logic [3:0]  wm [$];

    program_load_ingest dut (
        .axi4_mm_clk                  (clk),
        .axi4_mm_rst_n                (rst_n),
        .program_load_en              (en),
        .program_load_aw_valid        (awv),
        .program_load_aw_ready        (awr),
        .program_load_aw_payload_addr (addr),
        .program_load_w_valid         (wv),
        .program_load_w_ready         (wr),
        .program_load_w_payload_data  (wdat),
        .program_load_w_payload_strb  (strb),
        .ram_we                       (ram_we),
        .ram_ready                    (ram_ready),
        .ram_addr                     (ram_addr),
        .ram_wdata                    (ram_wdata),
        .ram_wmask                    (ram_wmask),
        .load_busy                    (busy),
        .load_err                     (err),
        .load_beats                   (beats),
        .load_checksum                (csum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && ram_we && ram_ready) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
            wm.push_back(ram_wmask);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [511:0] ramp(input logic [31:0] b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = b + 32'(i);
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wa.delete();
        wd.delete();
        wm.delete();
    endtask

    task automatic send_beat(input logic [14:0] a, input logic [511:0] d, input logic [63:0] s);
        int n;
        addr = a; wdat = d; strb = s; awv = 1'b1; wv = 1'b1;
        #1;
        for (n = 0; n < 40 && !(awr && wr); n++) step();
        cmp++;
        if (!(awr && wr)) begin
            bad++;
            $display("FAIL send_accept: readies %b%b, required 11", awr, wr);
        end
        step();
        awv = 1'b0; wv = 1'b0;
    endtask

    task automatic wait_idle;
        for (int n = 0; n < 64 && busy; n++) step();
        cmp++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: busy %b, required 0", busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; awv = 1'b0; wv = 1'b0; ram_ready = 1'b1;
        addr = '0; wdat = '0; strb = '0;
        repeat (2) step();
        cmp++;
        if ({ram_we, awr, wr, busy, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: we/awr/wr/busy/err %b, required 00000", {ram_we, awr, wr, busy, err});
        end
        cmp++;
        if (beats !== 16'h0 || csum !== 32'h0) begin
            bad++;
            $display("FAIL reset_counters: beats %h csum %h, required 0 0", beats, csum);
        end
        cmp++;
        if (ram_addr !== 13'h0 || ram_wdata !== 32'h0 || ram_wmask !== 4'h0) begin
            bad++;
            $display("FAIL reset_ram: addr %h data %h mask %h, required 0 0 0", ram_addr, ram_wdata, ram_wmask);
        end
        rst_n = 1'b1; en = 1'b1;
        step();
    endtask

    task automatic test_basic;
        int t;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        send_beat(15'h0040, ramp(32'h0), '1);
        cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 13'h10) begin
            bad++;
            $display("FAIL basic_first: we %b addr %h, required 1 010", ram_we, ram_addr);
        end
        t = 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (busy !== 1'b1) t++;
        end
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL basic_busy_window: %0d low cycles, required 0", t);
        end
        step();
        cmp++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_end: busy %b, required 0", busy);
        end
        cmp++;
        if (beats !== b0 + 16'd1) begin
            bad++;
            $display("FAIL basic_beats: %h, required %h", beats, b0 + 16'd1);
        end
        cmp++;
        if (wa.size() != 16) begin
            bad++;
            $display("FAIL basic_count: %0d writes, required 16", wa.size());
        end
        for (int i = 0; i < wa.size(); i++) begin
            cmp++;
            if (wa[i] !== 13'(16 + i) || wd[i] !== 32'(i) || wm[i] !== 4'hF) begin
                bad++;
                $display("FAIL basic_word%0d: addr %h data %h mask %h, required %h %h f", i, wa[i], wd[i], wm[i], 13'(16 + i), 32'(i));
            end
        end
    endtask

    task automatic test_skew;
        int t;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        addr = 15'h0100; wdat = ramp(32'h3000_0000); strb = '1;
        awv = 1'b1;
        #1;
        t = 0;
        for (int k = 0; k < 3; k++) begin
            if (awr !== 1'b0 || busy !== 1'b0) t++;
            step();
        end
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL skew_wait: %0d cycles with aw_ready or busy high, required 0", t);
        end
        wv = 1'b1;
        #1;
        cmp++;
        if (awr !== 1'b1 || wr !== 1'b1) begin
            bad++;
            $display("FAIL skew_ready: readies %b%b, required 11", awr, wr);
        end
        step();
        awv = 1'b0; wv = 1'b0;
        cmp++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL skew_accept: busy %b, required 1", busy);
        end
        wait_idle();
        repeat (2) step();
        cmp++;
        if (beats !== b0 + 16'd1 || wa.size() != 16 || busy !== 1'b0) begin
            bad++;
            $display("FAIL skew_single: beats %h writes %0d busy %b, required %h 16 0", beats, wa.size(), busy, b0 + 16'd1);
        end
    endtask

    task automatic test_sparse;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        send_beat(15'h0080, ramp(32'h5000_0000), 64'h0000_0000_0000_00F0);
        step();
        cmp++;
        if (ram_we !== 1'b1 || ram_addr !== 13'h21 || ram_wdata !== 32'h5000_0001 || ram_wmask !== 4'hF) begin
            bad++;
            $display("FAIL sparse_write: we %b addr %h data %h mask %h, required 1 021 50000001 f", ram_we, ram_addr, ram_wdata, ram_wmask);
        end
        repeat (14) step();
        cmp++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL sparse_busy15: busy %b, required 1", busy);
        end
        step();
        cmp++;
        if (busy !== 1'b0 || beats !== b0 + 16'd1) begin
            bad++;
            $display("FAIL sparse_done: busy %b beats %h, required 0 %h", busy, beats, b0 + 16'd1);
        end
        cmp++;
        if (wa.size() != 1 || (wa.size() == 1 && (wa[0] !== 13'h21 || wm[0] !== 4'hF))) begin
            bad++;
            $display("FAIL sparse_log: %0d writes, required 1 at 021 mask f", wa.size());
        end
    endtask

    task automatic test_backpressure;
        int t;
        clear_log();
        send_beat(15'h00C0, ramp(32'hA000_0000), '1);
        repeat (3) step();
        cmp++;
        if (ram_addr !== 13'h33) begin
            bad++;
            $display("FAIL bp_word3: addr %h, required 033", ram_addr);
        end
        ram_ready = 1'b0;
        #1;
        t = 0;
        for (int k = 0; k < 6; k++) begin
            if (ram_we !== 1'b1 || ram_addr !== 13'h33 || ram_wdata !== 32'hA000_0003 || ram_wmask !== 4'hF) t++;
            if (k < 5) step();
        end
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable samples, required 0", t);
        end
        ram_ready = 1'b1;
        wait_idle();
        cmp++;
        if (wa.size() != 16) begin
            bad++;
            $display("FAIL bp_count: %0d writes, required 16", wa.size());
        end
        t = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 13'(48 + i) || wd[i] !== 32'hA000_0000 + 32'(i)) t++;
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL bp_order: %0d misordered writes, required 0", t);
        end
    endtask

    task automatic test_abort_misalign;
        int t, n;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        cmp++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_initial: %b, required 0", err);
        end
        send_beat(15'h0100, ramp(32'hC000_0000), '1);
        repeat (7) step();
        cmp++;
        if (ram_addr !== 13'h47) begin
            bad++;
            $display("FAIL abort_word7: addr %h, required 047", ram_addr);
        end
        en = 1'b0;
        step();
        cmp++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            bad++;
            $display("FAIL abort_stop: busy %b we %b, required 0 0", busy, ram_we);
        end
        n = wa.size();
        awv = 1'b1; wv = 1'b1;
        #1;
        cmp++;
        if (awr !== 1'b0 || wr !== 1'b0) begin
            bad++;
            $display("FAIL en_low_ready: readies %b%b, required 00", awr, wr);
        end
        t = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ram_we !== 1'b0 || busy !== 1'b0) t++;
        end
        awv = 1'b0; wv = 1'b0;
        cmp++;
        if (t != 0 || wa.size() != n) begin
            bad++;
            $display("FAIL abort_quiet: %0d active samples, %0d extra writes, required 0 0", t, wa.size() - n);
        end
        cmp++;
        if (beats !== b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL abort_status: beats %h err %b, required %h 0", beats, err, b0);
        end
        en = 1'b1;
        clear_log();
        send_beat(15'h0044, ramp(32'h1111_0000), '1);
        cmp++;
        if (err !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'h10) begin
            bad++;
            $display("FAIL misalign_start: err %b we %b addr %h, required 1 1 010", err, ram_we, ram_addr);
        end
        wait_idle();
        cmp++;
        if (err !== 1'b1 || beats !== b0 + 16'd1 || wa.size() != 16) begin
            bad++;
            $display("FAIL misalign_done: err %b beats %h writes %0d, required 1 %h 16", err, beats, wa.size(), b0 + 16'd1);
        end
    endtask

    task automatic test_zero_strobe;
        int t;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        send_beat(15'h0200, ramp(32'hDEAD_0000), '0);
        t = (ram_we !== 1'b0 || busy !== 1'b1) ? 1 : 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (ram_we !== 1'b0 || busy !== 1'b1) t++;
        end
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL zero_window: %0d bad samples, required 0", t);
        end
        step();
        cmp++;
        if (busy !== 1'b0 || beats !== b0 + 16'd1 || wa.size() != 0) begin
            bad++;
            $display("FAIL zero_done: busy %b beats %h writes %0d, required 0 %h 0", busy, beats, wa.size(), b0 + 16'd1);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        logic [15:0] b0;
        clear_log();
        b0 = beats;
        addr = 15'h0300; wdat = ramp(32'h7700_0000); strb = '1;
        awv = 1'b1; wv = 1'b1;
        #1;
        step();
        t = 0;
        for (int k = 0; k < 16; k++) begin
            if (awr !== 1'b0 || wr !== 1'b0 || busy !== 1'b1) t++;
            if (k < 15) step();
        end
        cmp++;
        if (t != 0) begin
            bad++;
            $display("FAIL b2b_split: %0d bad samples, required 0", t);
        end
        step();
        cmp++;
        if (busy !== 1'b0 || awr !== 1'b1 || wr !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap: busy %b readies %b%b, required 0 11", busy, awr, wr);
        end
        step();
        awv = 1'b0; wv = 1'b0;
        cmp++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: busy %b, required 1", busy);
        end
        wait_idle();
        cmp++;
        if (beats !== b0 + 16'd2 || wa.size() != 32) begin
            bad++;
            $display("FAIL b2b_done: beats %h writes %0d, required %h 32", beats, wa.size(), b0 + 16'd2);
        end
    endtask

    task automatic test_checksum;
        logic [31:0] exp_sum;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clear_log();
        send_beat(15'h0000, {16{32'h0101_0101}}, '1);
        wait_idle();
        send_beat(15'h0040, {16{32'h0101_0101}}, '1);
        wait_idle();
`ifdef PROGRAM_LOAD_CHECKSUM_EN
        exp_sum = 32'h2020_2020;
`else
        exp_sum = 32'h0;
`endif
        cmp++;
        if (csum !== exp_sum || beats !== 16'd2) begin
            bad++;
            $display("FAIL checksum: csum %h beats %h, required %h 0002", csum, beats, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_sparse();
        test_backpressure();
        test_abort_misalign();
        test_zero_strobe();
        test_back_to_back();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
